// File: rtl/arith_pkg.sv
// Shared types and defaults for the sequential arithmetic blocks.
package arith_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int SLICE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cs_slice.sv
// Combinational SLICE-bit carry-select cell: both carry-in cases are resolved
// in parallel and the real carry-in picks one.
module cs_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] sum0;
  logic [SLICE:0] sum1;

  assign sum0 = {1'b0, x} + {1'b0, y};
  assign sum1 = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, 1'b1};

  assign {cout, s} = cin ? sum1 : sum0;

endmodule

// File: rtl/borrow_select_subtractor_seq.sv
// Multi-cycle a - b - borrow_in, one carry-select slice per clock, LSB first.
// Result appears NSLICE edges after accept and is held until out_ready.
module borrow_select_subtractor_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SLICE = SLICE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDXW-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic            c;
  logic            borrow_r;
  logic            ovf_r;
  logic            out_valid_r;

  logic [SLICE-1:0] x_s;
  logic [SLICE-1:0] y_s;
  logic [SLICE-1:0] s_s;
  logic             cout_s;
  logic             accept;
  logic             last;

  assign in_ready   = (state == IDLE);
  assign out_valid  = out_valid_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_r;
  assign ovf        = ovf_r;

  assign accept = in_valid && in_ready;
  assign last   = (state == CALC) && (idx == LAST_IDX);

  // Subtraction as a + ~b + carry, where carry = ~borrow.
  assign x_s = a_r[idx*SLICE +: SLICE];
  assign y_s = ~b_r[idx*SLICE +: SLICE];

  cs_slice #(.SLICE(SLICE)) u_slice (
    .x    (x_s),
    .y    (y_s),
    .cin  (c),
    .s    (s_s),
    .cout (cout_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_valid_r && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c           <= 1'b0;
      diff_r      <= '0;
      borrow_r    <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
        c   <= ~borrow_in;
        idx <= '0;
      end
      if (state == CALC) begin
        diff_r[idx*SLICE +: SLICE] <= s_s;
        c   <= cout_s;
        idx <= idx + IDXW'(1);
        if (last) begin
          // s_s[SLICE-1] is the new diff MSB, not yet visible in diff_r.
          borrow_r    <= ~cout_s;
          ovf_r       <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (s_s[SLICE-1] ^ a_r[WIDTH-1]);
          out_valid_r <= 1'b1;
        end
      end
      if ((state == DONE) && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Scoreboard bench: expectations pushed at accept, compared at output handshake.
module tb_borrow_select_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        borrow_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        borrow_out;
  logic        ovf;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_done;

  borrow_select_subtractor_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] full;
    res_t r;
    full     = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    r.diff   = full[15:0];
    r.borrow = full[16];
    r.ovf    = (x[15] != y[15]) && (full[15] != x[15]);
    return r;
  endfunction

  // Accept side pushes the expectation, output side pops and compares.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, borrow_in));
      if (out_valid && out_ready) begin
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          res_t e;
          e = exp_q.pop_front();
          check("sb_diff", 32'(diff), 32'(e.diff));
          check("sb_borrow", 32'(borrow_out), 32'(e.borrow));
          check("sb_ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic bi);
    bit ok = 0;
    a = x; b = y; borrow_in = bi; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Returns at the negedge where out_valid is seen high.
  task automatic wait_out();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    check("out_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] y, input logic bi,
                     input logic [15:0] ed, input logic eb, input logic eo, input string tag);
    send(x, y, bi);
    wait_out();
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // T1 with latency check
    send(16'h0000, 16'h0000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("t1_lat_edge%0d", k), 32'(out_valid), 32'(k == 4));
    end
    check("t1_diff", 32'(diff), 32'h0000FFFF);
    check("t1_borrow", 32'(borrow_out), 32'd1);
    check("t1_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;

    // T2, T3
    run(16'd128, 16'd127, 1'b0, 16'h0001, 1'b0, 1'b0, "t2a");
    run(16'd128, 16'd127, 1'b1, 16'h0000, 1'b0, 1'b0, "t2b");
    run(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "t3a");
    run(16'h7000, 16'h9000, 1'b0, 16'hE000, 1'b1, 1'b1, "t3b");

    // T4: hold under backpressure, in_valid ignored in DONE, back-to-back accept
    out_ready = 1'b0;
    send(16'h8000, 16'h0001, 1'b0);
    wait_out();
    @(posedge clk); #1;
    a = 16'd5; b = 16'd3; borrow_in = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_diff", 32'(diff), 32'h00007FFF);
      check("t4_hold_ovf", 32'(ovf), 32'd1);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_hs_valid", 32'(out_valid), 32'd0);
    check("t4_hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("t4_b2b_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_out();
    check("t4_b2b_diff", 32'(diff), 32'h00000002);
    @(posedge clk); #1;

    // T5: reset during second CALC cycle
    send(16'h1234, 16'h0101, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_diff", 32'(diff), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    run(16'd5, 16'd3, 1'b0, 16'h0002, 1'b0, 1'b0, "t5_next");

    // T6: random traffic with random gaps and backpressure
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          int gap;
          gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t6_idle_at_end", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
